fetch_stage: RTL

IF stage of the 5-stage pipeline. Owns the program counter, drives the combinational instruction memory address, and registers the returned word into the IF/ID pipeline register consumed by decode. Handles hazard-unit stalls and EX-stage redirects (branch/jump), inserting bubbles on redirect, and keeps a delivered-instruction counter for debug and performance.

---
 rtl/fetch_if.sv | 50 +++++
 rtl/fetch_stage.sv | 87 ++++++++
 2 files changed

// File: rtl/fetch_if.sv
// Bundle between the IF stage and its surroundings: instruction memory port,
// hazard/redirect controls from later stages, and the IF/ID register contents.
interface fetch_if #(
   parameter int CNT_WIDTH = 32
);
   logic [31:0]          imem_addr;
   logic [31:0]          imem_rdata;
   logic                 stall;
   logic                 redirect_valid;
   logic [31:0]          redirect_target;
   logic                 flush;
   logic                 if_id_valid;
   logic [31:0]          if_id_inst;
   logic [31:0]          if_id_pc;
   logic [31:0]          if_id_pc_plus4;
   logic                 misaligned_err;
   logic [CNT_WIDTH-1:0] inst_count;

   // Fetch stage side: drives the memory address and the IF/ID register.
   modport master (
      output imem_addr,
      input  imem_rdata,
      input  stall,
      input  redirect_valid,
      input  redirect_target,
      input  flush,
      output if_id_valid,
      output if_id_inst,
      output if_id_pc,
      output if_id_pc_plus4,
      output misaligned_err,
      output inst_count
   );

   // Environment side: memory, hazard unit, EX stage and decode.
   modport slave (
      input  imem_addr,
      output imem_rdata,
      output stall,
      output redirect_valid,
      output redirect_target,
      output flush,
      input  if_id_valid,
      input  if_id_inst,
      input  if_id_pc,
      input  if_id_pc_plus4,
      input  misaligned_err,
      input  inst_count
   );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, addresses instruction memory combinationally from pc_q
// and registers the returned word into IF/ID, honouring stall, redirect and flush.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INST  = 32'h0000_0000,
   parameter int          CNT_WIDTH = 32
) (
   input  logic     clk,
   input  logic     reset,
   fetch_if.master  bus
);

   logic [31:0]          pc_q, pc_d;
   logic                 valid_q, valid_d;
   logic [31:0]          inst_q, inst_d;
   logic [31:0]          id_pc_q, id_pc_d;
   logic [31:0]          id_pc4_q, id_pc4_d;
   logic                 err_q, err_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [31:0]          pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   // Control semantics: there is no valid/ready pair here. Each cycle the word
   // at imem_rdata is accepted into IF/ID only when neither redirect_valid,
   // flush nor stall is asserted. redirect_valid beats stall; a bubble keeps the
   // old pc/pc_plus4 so decode only needs to look at if_id_valid.
   always_comb begin
      pc_d     = pc_q;
      valid_d  = valid_q;
      inst_d   = inst_q;
      id_pc_d  = id_pc_q;
      id_pc4_d = id_pc4_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      if (bus.redirect_valid) begin
         pc_d    = {bus.redirect_target[31:2], 2'b00};
         valid_d = 1'b0;
         inst_d  = NOP_INST;
         if (bus.redirect_target[1:0] != 2'b00) begin
            err_d = 1'b1;
         end
      end else if (bus.flush) begin
         valid_d = 1'b0;
         inst_d  = NOP_INST;
         if (!bus.stall) begin
            pc_d = pc_plus4;
         end
      end else if (!bus.stall) begin
         pc_d     = pc_plus4;
         valid_d  = 1'b1;
         inst_d   = bus.imem_rdata;
         id_pc_d  = pc_q;
         id_pc4_d = pc_plus4;
         cnt_d    = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         valid_q  <= 1'b0;
         inst_q   <= NOP_INST;
         id_pc_q  <= 32'h0;
         id_pc4_q <= 32'h0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         pc_q     <= pc_d;
         valid_q  <= valid_d;
         inst_q   <= inst_d;
         id_pc_q  <= id_pc_d;
         id_pc4_q <= id_pc4_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.imem_addr      = pc_q;
   assign bus.if_id_valid    = valid_q;
   assign bus.if_id_inst     = inst_q;
   assign bus.if_id_pc       = id_pc_q;
   assign bus.if_id_pc_plus4 = id_pc4_q;
   assign bus.misaligned_err = err_q;
   assign bus.inst_count     = cnt_q;

endmodule
